// File: rtl/hyperbus_pkg.sv
// Shared definitions for the hyperbus arbiter: FSM state encoding,
// address width and an index-width helper.
package hyperbus_pkg;

  localparam int ADR_W = 32;

  // One-hot state encoding; ERROR is terminal until reset.
  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_ISSUE = 4'b0010,
    S_BUSY  = 4'b0100,
    S_ERROR = 4'b1000
  } arb_state_t;

  // Bits needed to index n requesters; never less than 1 so ports stay legal.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/hyperbus_rr_pick.sv
// Combinational round-robin picker: the winner is the first active
// request strictly after the pointer, wrapping modulo NREQ.
module hyperbus_rr_pick
  import hyperbus_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  // Scan NREQ positions starting just after the pointer; first hit wins.
  always_comb begin
    int t;
    // NOTE: every output gets a default before the loop so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      t = int'(ptr) + k;
      if (t >= NREQ) t = t - NREQ;
      if (!any && req[t[IW-1:0]]) begin
        any = 1'b1;
        idx = t[IW-1:0];
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/hyperbus_arbiter.sv
// Round-robin arbiter sharing one hyperbus controller between NREQ masters.
// Latches the winner's address/data/strobe, holds the strobe through the
// controller's busy window, returns read data and a done pulse to the owner.
// Optional watchdog: define HBUS_ARB_TIMEOUT_EN to force ERROR when a grant
// lasts TIMEOUT cycles; without it the arbiter waits indefinitely.
module hyperbus_arbiter
  import hyperbus_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req_rrq,
  input  logic [NREQ-1:0]       req_wrq,
  input  logic [NREQ*32-1:0]    req_adr,
  input  logic [NREQ*2*WIDTH-1:0] req_dat,
  output logic [NREQ-1:0]       req_gnt,
  output logic [NREQ-1:0]       req_done,
  output logic [2*WIDTH-1:0]    rd_dat,
  output logic [NREQ-1:0]       rd_valid,
  output logic                  err_o,
  output logic [31:0]           hb_adr_o,
  output logic [2*WIDTH-1:0]    hb_dat_o,
  output logic                  hb_rrq_o,
  output logic                  hb_wrq_o,
  input  logic [2*WIDTH-1:0]    hb_dat_i,
  input  logic                  hb_dvalid_i,
  input  logic                  hb_busy_i,
  input  logic                  hb_error_i
);

  localparam int IW = clog2(NREQ);
  localparam int DW = 2 * WIDTH;

  // Reject configurations the watchdog width and picker cannot represent.
  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
    $error("hyperbus_arbiter: NREQ must be 2..8 and TIMEOUT 1..65535");
  end

  arb_state_t      state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   owner;
  logic [NREQ-1:0] active;
  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            wd_expired;

  assign active = req_rrq | req_wrq;

  hyperbus_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req (active),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

`ifdef HBUS_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;

  // Watchdog: zero while idle (so each grant starts from 0), counts per owned cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd_cnt <= '0;
    end else if (state == S_ISSUE || state == S_BUSY) begin
      wd_cnt <= wd_cnt + 16'd1;
    end else begin
      wd_cnt <= '0;
    end
  end

  // Expiry is flagged one cycle early so ERROR lands exactly TIMEOUT cycles after the grant.
  assign wd_expired = (state == S_ISSUE || state == S_BUSY) && (wd_cnt == 16'(TIMEOUT - 1));
`else
  assign wd_expired = 1'b0;
`endif

  // Arbiter FSM with registered grant, strobes, address/data and pulses.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: data registers are reset too; every output must read 0 out of
    // reset, and the controller may sample hb_adr_o/hb_dat_o at any time.
    if (!rstn) begin
      state    <= S_IDLE;
      ptr      <= IW'(NREQ - 1);
      owner    <= '0;
      req_gnt  <= '0;
      req_done <= '0;
      rd_dat   <= '0;
      rd_valid <= '0;
      err_o    <= 1'b0;
      hb_adr_o <= '0;
      hb_dat_o <= '0;
      hb_rrq_o <= 1'b0;
      hb_wrq_o <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // updates from the same pre-edge values regardless of statement order.
      req_done <= '0;
      rd_valid <= '0;
      if (hb_error_i || wd_expired) begin
        state    <= S_ERROR;
        err_o    <= 1'b1;
        req_gnt  <= '0;
        hb_rrq_o <= 1'b0;
        hb_wrq_o <= 1'b0;
        hb_adr_o <= '0;
        hb_dat_o <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (!hb_busy_i && pick_any) begin
              state    <= S_ISSUE;
              owner    <= pick_idx;
              req_gnt  <= pick_gnt;
              hb_adr_o <= req_adr[ADR_W*pick_idx +: ADR_W];
              hb_dat_o <= req_dat[DW*pick_idx +: DW];
              // Read wins when both are set; the write stays pending.
              hb_rrq_o <= req_rrq[pick_idx];
              hb_wrq_o <= ~req_rrq[pick_idx];
            end
          end
          S_ISSUE: begin
            if (hb_busy_i) state <= S_BUSY;
          end
          S_BUSY: begin
            if (hb_dvalid_i) begin
              rd_dat   <= hb_dat_i;
              rd_valid <= req_gnt;
            end
            if (!hb_busy_i) begin
              state    <= S_IDLE;
              req_done <= req_gnt;
              req_gnt  <= '0;
              hb_rrq_o <= 1'b0;
              hb_wrq_o <= 1'b0;
              hb_adr_o <= '0;
              hb_dat_o <= '0;
              ptr      <= owner;
            end
          end
          S_ERROR: begin
            state <= S_ERROR;
          end
          default: begin
            state <= S_ERROR;
            err_o <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hyperbus_arbiter.sv
// Self-checking bench for hyperbus_arbiter: randomized requests served by a
// behavioural controller model, checked against a round-robin reference.
module tb_hyperbus_arbiter;

  localparam int NREQ    = 4;
  localparam int WIDTH   = 8;
  localparam int DW      = 2 * WIDTH;
  localparam int TIMEOUT = 255;

  logic                 clk;
  logic                 rstn;
  logic [NREQ-1:0]      req_rrq;
  logic [NREQ-1:0]      req_wrq;
  logic [NREQ*32-1:0]   req_adr;
  logic [NREQ*DW-1:0]   req_dat;
  logic [NREQ-1:0]      req_gnt;
  logic [NREQ-1:0]      req_done;
  logic [DW-1:0]        rd_dat;
  logic [NREQ-1:0]      rd_valid;
  logic                 err_o;
  logic [31:0]          hb_adr_o;
  logic [DW-1:0]        hb_dat_o;
  logic                 hb_rrq_o;
  logic                 hb_wrq_o;
  logic [DW-1:0]        hb_dat_i;
  logic                 hb_dvalid_i;
  logic                 hb_busy_i;
  logic                 hb_error_i;

  int n_checks = 0;
  int n_fail   = 0;
  int model_ptr;
  logic [DW-1:0] exp_rd_dat;

  hyperbus_arbiter #(
    .NREQ    (NREQ),
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_rrq     (req_rrq),
    .req_wrq     (req_wrq),
    .req_adr     (req_adr),
    .req_dat     (req_dat),
    .req_gnt     (req_gnt),
    .req_done    (req_done),
    .rd_dat      (rd_dat),
    .rd_valid    (rd_valid),
    .err_o       (err_o),
    .hb_adr_o    (hb_adr_o),
    .hb_dat_o    (hb_dat_o),
    .hb_rrq_o    (hb_rrq_o),
    .hb_wrq_o    (hb_wrq_o),
    .hb_dat_i    (hb_dat_i),
    .hb_dvalid_i (hb_dvalid_i),
    .hb_busy_i   (hb_busy_i),
    .hb_error_i  (hb_error_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: first active requester after the last owner, wrapping around.
  function automatic int rr_winner(input logic [NREQ-1:0] act);
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (model_ptr + k) % NREQ;
      if (act[i]) return i;
    end
    return -1;
  endfunction

  task automatic clear_inputs();
    req_rrq     = '0;
    req_wrq     = '0;
    req_adr     = '0;
    req_dat     = '0;
    hb_dat_i    = '0;
    hb_dvalid_i = 1'b0;
    hb_busy_i   = 1'b0;
    hb_error_i  = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rstn = 1'b0;
    #2;
    tick();
    rstn = 1'b1;
    model_ptr  = NREQ - 1;
    exp_rd_dat = '0;
  endtask

  // Controller model serving one grant. drop: 0 keep request, 1 requester
  // drops the served strobe after done, 2 requester drops everything mid-grant.
  task automatic serve(input bit dv_en, input logic [DW-1:0] dv_d, input int drop, output int w);
    logic [NREQ-1:0] act, exp_g;
    logic [31:0]     e_adr;
    logic [DW-1:0]   e_dat;
    bit              rd, dv;
    int              n_wait, n_busy;
    act = req_rrq | req_wrq;
    w   = rr_winner(act);
    if (w < 0) begin
      n_checks++; n_fail++;
      $display("FAIL serve_setup: no active request, got %b", act);
      return;
    end
    exp_g    = '0;
    exp_g[w] = 1'b1;
    rd       = req_rrq[w];
    e_adr    = req_adr[32*w +: 32];
    e_dat    = req_dat[DW*w +: DW];
    tick();
    n_checks++;
    if (req_gnt !== exp_g) begin
      n_fail++; $display("FAIL grant: got %b expected %b", req_gnt, exp_g);
    end
    n_checks++;
    if ({hb_rrq_o, hb_wrq_o} !== {rd, !rd}) begin
      n_fail++; $display("FAIL strobe_issue: got rrq=%b wrq=%b expected rrq=%b", hb_rrq_o, hb_wrq_o, rd);
    end
    n_checks++;
    if (hb_adr_o !== e_adr || hb_dat_o !== e_dat) begin
      n_fail++; $display("FAIL adr_dat: got %h/%h expected %h/%h", hb_adr_o, hb_dat_o, e_adr, e_dat);
    end
    if (drop == 2) begin
      req_rrq[w] = 1'b0;
      req_wrq[w] = 1'b0;
    end
    // Controller slow to raise busy; stray dvalid here must be ignored.
    n_wait = $urandom_range(0, 2);
    for (int c = 0; c < n_wait; c++) begin
      hb_dvalid_i = 1'b1;
      hb_dat_i    = DW'($urandom);
      tick();
      hb_dvalid_i = 1'b0;
      n_checks++;
      if (rd_valid !== '0 || req_gnt !== exp_g) begin
        n_fail++; $display("FAIL issue_hold: got rd_valid=%b gnt=%b expected 0/%b", rd_valid, req_gnt, exp_g);
      end
    end
    hb_busy_i = 1'b1;
    tick();
    n_busy = $urandom_range(1, 4);
    for (int c = 0; c < n_busy; c++) begin
      dv          = dv_en && (c == 0);
      hb_dvalid_i = dv;
      hb_dat_i    = dv ? dv_d : DW'($urandom);
      tick();
      if (dv) exp_rd_dat = dv_d;
      n_checks++;
      if (rd_valid !== (dv ? exp_g : '0) || rd_dat !== exp_rd_dat) begin
        n_fail++; $display("FAIL rd_data: got valid=%b dat=%h expected valid=%b dat=%h",
                           rd_valid, rd_dat, dv ? exp_g : '0, exp_rd_dat);
      end
      n_checks++;
      if (req_gnt !== exp_g || {hb_rrq_o, hb_wrq_o} !== {rd, !rd} || req_done !== '0) begin
        n_fail++; $display("FAIL busy_hold: got gnt=%b rrq=%b wrq=%b done=%b expected gnt=%b rrq=%b",
                           req_gnt, hb_rrq_o, hb_wrq_o, req_done, exp_g, rd);
      end
    end
    hb_dvalid_i = 1'b0;
    hb_busy_i   = 1'b0;
    tick();
    n_checks++;
    if (req_done !== exp_g) begin
      n_fail++; $display("FAIL done: got %b expected %b", req_done, exp_g);
    end
    n_checks++;
    if (req_gnt !== '0 || hb_rrq_o !== 1'b0 || hb_wrq_o !== 1'b0 || hb_adr_o !== '0 || rd_dat !== exp_rd_dat) begin
      n_fail++; $display("FAIL release: got gnt=%b rrq=%b wrq=%b adr=%h rd_dat=%h expected all 0, rd_dat=%h",
                         req_gnt, hb_rrq_o, hb_wrq_o, hb_adr_o, rd_dat, exp_rd_dat);
    end
    model_ptr = w;
    if (drop == 1) begin
      if (rd) req_rrq[w] = 1'b0;
      else    req_wrq[w] = 1'b0;
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rstn = 1'b0;
    #2;
    n_checks++;
    if ({req_gnt, req_done, rd_dat, rd_valid, err_o, hb_adr_o, hb_dat_o, hb_rrq_o, hb_wrq_o} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got gnt=%b done=%b err=%b adr=%h rrq=%b wrq=%b expected all 0",
                         req_gnt, req_done, err_o, hb_adr_o, hb_rrq_o, hb_wrq_o);
    end
    tick();
    rstn       = 1'b1;
    model_ptr  = NREQ - 1;
    exp_rd_dat = '0;
  endtask

  task automatic test_single();
    int w;
    req_rrq[0]      = 1'b1;
    req_adr[31:0]   = 32'h0000_0100;
    req_dat[DW-1:0] = DW'($urandom);
    serve(1'b0, '0, 2, w);
    tick();
    n_checks++;
    if (req_done !== '0 || req_gnt !== '0) begin
      n_fail++; $display("FAIL single_quiet: got done=%b gnt=%b expected 0/0", req_done, req_gnt);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    do_reset();
    req_rrq = '1;
    for (int i = 0; i < NREQ; i++) req_adr[32*i +: 32] = 32'h1000 * (i + 1);
    for (int n = 0; n < 5; n++) serve($urandom_range(0, 1) == 1, DW'($urandom), 0, w);
    req_rrq = '0;
  endtask

  task automatic test_read_before_write();
    int w;
    do_reset();
    req_rrq[2] = 1'b1;
    req_wrq[2] = 1'b1;
    req_adr[64 +: 32] = 32'hCAFE_0200;
    req_dat[2*DW +: DW] = 16'h1234;
    serve(1'b0, '0, 1, w);
    serve(1'b0, '0, 1, w);
    n_checks++;
    if (req_rrq[2] !== 1'b0 || req_wrq[2] !== 1'b0) begin
      n_fail++; $display("FAIL rw_sequence: got rrq=%b wrq=%b pending expected none", req_rrq[2], req_wrq[2]);
    end
  endtask

  task automatic test_read_data();
    int w;
    req_rrq[1] = 1'b1;
    req_adr[32 +: 32] = 32'h0000_0040;
    serve(1'b1, 16'hA55A, 1, w);
    n_checks++;
    if (rd_dat !== 16'hA55A) begin
      n_fail++; $display("FAIL read_hold: got %h expected a55a", rd_dat);
    end
  endtask

  task automatic test_random();
    int w;
    do_reset();
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_rrq[i] && !req_wrq[i] && $urandom_range(0, 1) == 1) begin
          req_rrq[i] = 1'($urandom_range(0, 1));
          req_wrq[i] = 1'($urandom_range(0, 1));
          req_adr[32*i +: 32] = $urandom;
          req_dat[DW*i +: DW] = DW'($urandom);
        end
      end
      if ((req_rrq | req_wrq) == '0) req_wrq[n % NREQ] = 1'b1;
      serve($urandom_range(0, 1) == 1, DW'($urandom), 1, w);
    end
  endtask

  task automatic test_error();
    int w;
    do_reset();
    req_rrq[0] = 1'b1;
    tick();
    n_checks++;
    if (req_gnt !== 4'b0001) begin
      n_fail++; $display("FAIL err_pre_grant: got %b expected 0001", req_gnt);
    end
    hb_busy_i = 1'b1;
    tick();
    hb_error_i = 1'b1;
    tick();
    hb_error_i = 1'b0;
    hb_busy_i  = 1'b0;
    n_checks++;
    if (err_o !== 1'b1 || req_gnt !== '0 || hb_rrq_o !== 1'b0 || req_done !== '0) begin
      n_fail++; $display("FAIL error_enter: got err=%b gnt=%b rrq=%b done=%b expected 1/0/0/0",
                         err_o, req_gnt, hb_rrq_o, req_done);
    end
    req_rrq = '1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if (err_o !== 1'b1 || req_gnt !== '0 || req_done !== '0) begin
        n_fail++; $display("FAIL error_sticky: got err=%b gnt=%b done=%b expected 1/0/0", err_o, req_gnt, req_done);
      end
    end
    do_reset();
    n_checks++;
    if (err_o !== 1'b0) begin
      n_fail++; $display("FAIL error_clear: got %b expected 0", err_o);
    end
    req_rrq[0] = 1'b1;
    serve(1'b0, '0, 1, w);
    // Asynchronous reset in the middle of a grant.
    req_rrq[1] = 1'b1;
    tick();
    rstn = 1'b0;
    #2;
    n_checks++;
    if (req_gnt !== '0 || hb_rrq_o !== 1'b0 || hb_adr_o !== '0) begin
      n_fail++; $display("FAIL async_reset: got gnt=%b rrq=%b adr=%h expected 0", req_gnt, hb_rrq_o, hb_adr_o);
    end
    do_reset();
  endtask

  task automatic test_timeout();
    req_rrq[0] = 1'b1;
    tick();
    for (int c = 0; c < TIMEOUT + 45; c++) tick();
    n_checks++;
`ifdef HBUS_ARB_TIMEOUT_EN
    if (err_o !== 1'b1 || req_gnt !== '0) begin
      n_fail++; $display("FAIL timeout: got err=%b gnt=%b expected 1/0", err_o, req_gnt);
    end
`else
    if (err_o !== 1'b0 || req_gnt !== 4'b0001 || hb_rrq_o !== 1'b1) begin
      n_fail++; $display("FAIL no_timeout: got err=%b gnt=%b rrq=%b expected 0/0001/1", err_o, req_gnt, hb_rrq_o);
    end
`endif
    do_reset();
  endtask

  initial begin
    rstn = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_back_to_back();
    test_read_before_write();
    test_read_data();
    test_random();
    test_error();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
